// File: rtl/uart_cmd_loader.sv
// uart_cmd_loader
//   Decodes the host command byte stream coming out of the UART receiver and
//   drives the MIPS instruction memory write port and debug run/step controls.
//
//   Protocol (one byte per rx_valid strobe):
//     0x01 N b0 b1 b2 b3 ...  LOAD: N words, each sent as 4 bytes, LSB first,
//                             written to consecutive word addresses from 0.
//     0x02                    RUN:  one-cycle run pulse.
//     0x03                    STEP: one-cycle step pulse.
//     anything else           err pulse.
//   A LOAD that stalls for TIMEOUT idle cycles is aborted with err.
//
// Ports:
//   clk, reset          system clock, synchronous active-high reset
//   rx_data, rx_valid   received byte and its one-cycle strobe
//   mem_we, mem_addr,   instruction-memory write strobe, word address and data
//   mem_wdata
//   run, step           processor control pulses
//   load_done, err      LOAD completion / abort-or-bad-command pulses
//   busy, state_dbg     FSM status (state_dbg: IDLE=0, COUNT=1, DATA=2)
//
// Every response is registered and appears one cycle after the causing byte.

module uart_cmd_loader #(
  parameter int DATA_W  = 8,
  parameter int WORD_W  = 32,
  parameter int ADDR_W  = 8,
  parameter int TIMEOUT = 3000000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] rx_data,
  input  logic              rx_valid,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [WORD_W-1:0] mem_wdata,
  output logic              run,
  output logic              step,
  output logic              load_done,
  output logic              err,
  output logic              busy,
  output logic [1:0]        state_dbg
);

  localparam int BYTES = WORD_W / DATA_W;
  localparam int TMO_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT - 1);

  localparam logic [DATA_W-1:0] CMD_LOAD = DATA_W'(1);
  localparam logic [DATA_W-1:0] CMD_RUN  = DATA_W'(2);
  localparam logic [DATA_W-1:0] CMD_STEP = DATA_W'(3);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    COUNT = 2'd1,
    DATA  = 2'd2
  } state_t;

  state_t              state, state_nxt;
  logic [1:0]          byte_idx, byte_idx_nxt;
  logic [ADDR_W-1:0]   word_idx, word_idx_nxt;
  logic [DATA_W-1:0]   word_cnt, word_cnt_nxt;
  logic [TMO_W-1:0]    tmo_cnt, tmo_cnt_nxt;
  logic [WORD_W-1:0]   asm_word, asm_word_nxt;
  logic [WORD_W-1:0]   asm_ins;

  logic                we_q, we_nxt;
  logic [ADDR_W-1:0]   addr_q, addr_nxt;
  logic [WORD_W-1:0]   wdata_q, wdata_nxt;
  logic                run_q, run_nxt;
  logic                step_q, step_nxt;
  logic                done_q, done_nxt;
  logic                err_q, err_nxt;

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      byte_idx <= '0;
      word_idx <= '0;
      word_cnt <= '0;
      tmo_cnt  <= '0;
      asm_word <= '0;
      we_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      run_q    <= 1'b0;
      step_q   <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state    <= state_nxt;
      byte_idx <= byte_idx_nxt;
      word_idx <= word_idx_nxt;
      word_cnt <= word_cnt_nxt;
      tmo_cnt  <= tmo_cnt_nxt;
      asm_word <= asm_word_nxt;
      we_q     <= we_nxt;
      addr_q   <= addr_nxt;
      wdata_q  <= wdata_nxt;
      run_q    <= run_nxt;
      step_q   <= step_nxt;
      done_q   <= done_nxt;
      err_q    <= err_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    byte_idx_nxt = byte_idx;
    word_idx_nxt = word_idx;
    word_cnt_nxt = word_cnt;
    tmo_cnt_nxt  = tmo_cnt;
    asm_word_nxt = asm_word;
    we_nxt       = 1'b0;
    addr_nxt     = addr_q;
    wdata_nxt    = wdata_q;
    run_nxt      = 1'b0;
    step_nxt     = 1'b0;
    done_nxt     = 1'b0;
    err_nxt      = 1'b0;

    // Assembly register with the incoming byte dropped into its lane.
    asm_ins = asm_word;
    for (int k = 0; k < BYTES; k++) begin
      if (byte_idx == 2'(k)) asm_ins[k*DATA_W +: DATA_W] = rx_data;
    end

    if (rx_valid) begin
      case (state)
        IDLE: begin
          case (rx_data)
            CMD_LOAD: begin
              state_nxt    = COUNT;
              word_idx_nxt = '0;
              tmo_cnt_nxt  = '0;
            end
            CMD_RUN:  run_nxt  = 1'b1;
            CMD_STEP: step_nxt = 1'b1;
            default:  err_nxt  = 1'b1;
          endcase
        end
        COUNT: begin
          tmo_cnt_nxt = '0;
          if (rx_data == '0) begin
            done_nxt  = 1'b1;
            state_nxt = IDLE;
          end else begin
            word_cnt_nxt = rx_data;
            byte_idx_nxt = '0;
            asm_word_nxt = '0;
            state_nxt    = DATA;
          end
        end
        DATA: begin
          tmo_cnt_nxt = '0;
          if (byte_idx == 2'(BYTES - 1)) begin
            we_nxt       = 1'b1;
            addr_nxt     = word_idx;
            wdata_nxt    = asm_ins;
            word_idx_nxt = word_idx + ADDR_W'(1);
            word_cnt_nxt = word_cnt - DATA_W'(1);
            byte_idx_nxt = '0;
            asm_word_nxt = '0;
            if (word_cnt == DATA_W'(1)) begin
              done_nxt  = 1'b1;
              state_nxt = IDLE;
            end
          end else begin
            asm_word_nxt = asm_ins;
            byte_idx_nxt = byte_idx + 2'd1;
          end
        end
        default: state_nxt = IDLE;
      endcase
    end else if (state != IDLE) begin
      // Inter-byte watchdog; a byte arriving on the expiry cycle takes the
      // branch above, so it always wins over the abort.
      if (tmo_cnt == TMO_LAST) begin
        err_nxt      = 1'b1;
        state_nxt    = IDLE;
        byte_idx_nxt = '0;
        asm_word_nxt = '0;
        tmo_cnt_nxt  = '0;
      end else begin
        tmo_cnt_nxt = tmo_cnt + TMO_W'(1);
      end
    end
  end

  // Pulses are masked while reset is held so nothing fires during reset,
  // even a pulse registered on the edge just before reset was raised.
  assign mem_we    = we_q & ~reset;
  assign run       = run_q & ~reset;
  assign step      = step_q & ~reset;
  assign load_done = done_q & ~reset;
  assign err       = err_q & ~reset;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign busy      = (state != IDLE);
  assign state_dbg = state;

endmodule

// File: tb/tb_uart_cmd_loader.sv
// Self-checking bench for uart_cmd_loader: directed command sequences followed
// by randomized byte traffic, compared every cycle against a behavioural
// protocol model.
module tb_uart_cmd_loader;
  localparam int DATA_W  = 8;
  localparam int WORD_W  = 32;
  localparam int ADDR_W  = 2;
  localparam int TIMEOUT = 50;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic [DATA_W-1:0] rx_data = '0;
  logic              rx_valid = 1'b0;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [WORD_W-1:0] mem_wdata;
  logic              run, step, load_done, err, busy;
  logic [1:0]        state_dbg;

  uart_cmd_loader #(
    .DATA_W(DATA_W), .WORD_W(WORD_W), .ADDR_W(ADDR_W), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk), .reset(reset), .rx_data(rx_data), .rx_valid(rx_valid),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .run(run), .step(step), .load_done(load_done), .err(err),
    .busy(busy), .state_dbg(state_dbg)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Behavioural protocol model: mode 0=idle, 1=awaiting count, 2=receiving words.
  int          m_mode = 0;
  int          m_idle = 0;
  int          m_left = 0;
  int          m_widx = 0;
  logic [7:0]  m_bytes[$];
  logic        e_we, e_run, e_step, e_done, e_err;
  logic [31:0] e_wdata;
  int          e_addr;

  // Writes actually observed on the DUT port.
  int          obs_a[$];
  logic [31:0] obs_d[$];

  task automatic model_step(input logic r, input logic v, input logic [7:0] d);
    e_we = 0; e_run = 0; e_step = 0; e_done = 0; e_err = 0;
    if (r) begin
      m_mode = 0; m_idle = 0; m_left = 0; m_widx = 0;
      m_bytes.delete();
      e_addr = 0; e_wdata = 0;
    end else if (m_mode == 0) begin
      if (v) begin
        if (d == 8'h01) begin m_mode = 1; m_widx = 0; m_idle = 0; end
        else if (d == 8'h02) e_run = 1;
        else if (d == 8'h03) e_step = 1;
        else e_err = 1;
      end
    end else if (v) begin
      m_idle = 0;
      if (m_mode == 1) begin
        if (d == 0) begin e_done = 1; m_mode = 0; end
        else begin m_left = d; m_mode = 2; m_bytes.delete(); end
      end else begin
        m_bytes.push_back(d);
        if (m_bytes.size() == 4) begin
          e_we = 1;
          e_addr = m_widx;
          e_wdata = {m_bytes[3], m_bytes[2], m_bytes[1], m_bytes[0]};
          m_widx = (m_widx + 1) % (1 << ADDR_W);
          m_left--;
          m_bytes.delete();
          if (m_left == 0) begin e_done = 1; m_mode = 0; end
        end
      end
    end else if (m_idle == TIMEOUT - 1) begin
      e_err = 1; m_mode = 0; m_idle = 0; m_bytes.delete();
    end else begin
      m_idle++;
    end
  endtask

  task automatic cyc(input logic r, input logic v, input logic [7:0] d);
    @(negedge clk);
    reset = r; rx_valid = v; rx_data = d;
    @(posedge clk);
    model_step(r, v, d);
    #1;
    chk("mem_we", mem_we, e_we);
    if (e_we || r) begin
      chk("mem_addr", mem_addr, e_addr);
      chk("mem_wdata", mem_wdata, e_wdata);
    end
    chk("run", run, e_run);
    chk("step", step, e_step);
    chk("load_done", load_done, e_done);
    chk("err", err, e_err);
    chk("state_dbg", state_dbg, m_mode);
    chk("busy", busy, m_mode != 0);
    if (mem_we) begin
      obs_a.push_back(int'(mem_addr));
      obs_d.push_back(mem_wdata);
    end
  endtask

  task automatic send(input logic [7:0] d);
    cyc(1'b0, 1'b1, d);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 8'($urandom));
  endtask

  initial begin
    int n0;
    logic [7:0] seq[10];
    int wrap_exp[5];

    cyc(1'b1, 1'b0, 8'h00);
    cyc(1'b1, 1'b1, 8'h02);

    // RUN
    send(8'h02); idle(3);

    // Two-word LOAD with the documented values
    seq = '{8'h01, 8'h02, 8'h78, 8'h56, 8'h34, 8'h12, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
    obs_a.delete(); obs_d.delete();
    for (int i = 0; i < 10; i++) begin send(seq[i]); idle(i % 2); end
    idle(2);
    chk("load2_count", obs_a.size(), 2);
    if (obs_a.size() == 2) begin
      chk("load2_a0", obs_a[0], 0);
      chk("load2_d0", obs_d[0], 32'h12345678);
      chk("load2_a1", obs_a[1], 1);
      chk("load2_d1", obs_d[1], 32'hDEADBEEF);
    end

    // Bad command, then STEP
    send(8'h7F); idle(1); send(8'h03); idle(2);

    // Timeout mid-word, then RUN
    n0 = obs_a.size();
    send(8'h01); send(8'h01); send(8'hAA); send(8'hBB);
    idle(TIMEOUT + 3);
    chk("tmo_no_write", obs_a.size(), n0);
    send(8'h02); idle(2);

    // Empty LOAD
    send(8'h01); send(8'h00); idle(2);

    // Reset after the third data byte
    n0 = obs_a.size();
    send(8'h01); send(8'h01); send(8'h11); send(8'h22); send(8'h33);
    cyc(1'b1, 1'b0, 8'h00);
    cyc(1'b0, 1'b1, 8'h44);
    idle(2);
    chk("reset_no_write", obs_a.size(), n0);

    // Byte arriving on the last allowed idle cycle is accepted
    send(8'h01); send(8'h01); idle(TIMEOUT - 1);
    send(8'hA1); idle(TIMEOUT - 1); send(8'hA2); send(8'hA3); send(8'hA4);
    idle(2);

    // Address wrap with a 2-bit address
    n0 = obs_a.size();
    wrap_exp = '{0, 1, 2, 3, 0};
    send(8'h01); send(8'h05);
    for (int i = 0; i < 20; i++) send(8'($urandom));
    idle(2);
    chk("wrap_count", obs_a.size() - n0, 5);
    if (obs_a.size() - n0 == 5)
      for (int i = 0; i < 5; i++) chk("wrap_addr", obs_a[n0 + i], wrap_exp[i]);

    // Randomized traffic
    for (int it = 0; it < 2500; it++) begin
      int sel;
      int p;
      logic [7:0] d;
      sel = $urandom_range(0, 99);
      if (sel < 2) begin
        cyc(1'b1, 1'b0, 8'($urandom));
      end else if (sel < 6) begin
        idle($urandom_range(TIMEOUT - 2, TIMEOUT + 1));
      end else begin
        idle($urandom_range(0, 2));
        p = $urandom_range(0, 9);
        if (p < 2) d = 8'h01;
        else if (p < 4) d = 8'h02;
        else if (p == 4) d = 8'h03;
        else if (p < 7) d = 8'($urandom_range(0, 6));
        else d = 8'($urandom);
        send(d);
      end
    end
    idle(3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
